// File: rtl/axi_sram_bridge_mp_pkg.sv
// Shared definitions for the multi-port SRAM-to-AXI3 bridge.
//   rd_state_t / wr_state_t : read and write channel FSM states
//   AXI_BURST_INCR / AXI_LEN_SINGLE : fixed AXI encodings (single-beat INCR)
package axi_sram_bridge_mp_pkg;

  typedef enum logic {
    R_IDLE,
    R_ADDR
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_AW_W,   // AW and W both pending
    W_AW,     // W done, AW pending
    W_W,      // AW done, W pending
    W_RESP
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

endpackage

// File: rtl/axi_sram_bridge_mp_rr_arbiter.sv
// Round-robin arbiter. The port granted last gets the lowest priority.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req        : per-port request (already qualified by eligibility)
//   i_accept     : grant taken this cycle, advance the pointer
//   o_grant      : one-hot grant
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_accept,
  output logic [NUM_PORTS-1:0] o_grant
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // r_ptr is the port with highest priority this cycle
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;

  always_comb begin
    int unsigned idx;
    logic        found;
    o_grant    = '0;
    w_next_ptr = r_ptr;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        w_next_ptr   = (idx == NUM_PORTS - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_ptr <= '0;
    else if (i_accept) r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/axi_sram_bridge_mp.sv
// Multi-port SRAM-like request interface to a single AXI3 master.
// One request accepted per cycle (round robin); single-beat reads and writes,
// AXI ID = port index. Reads may be outstanding up to RD_OUTSTANDING per port.
//   aclk/areset          : clock, synchronous active-high reset
//   ar*/r*, aw*/w*/b*    : AXI3 master channels
//   sram_req/wr/size/... : per-port requests, port p in slice p
//   sram_addr_ok/data_ok : per-port accept / completion pulses
//   sram_rdata           : read data, valid with sram_data_ok
// Optional macro AXI_RAW_HAZARD_CHECK_EN: block reads whose word address
// matches the write currently in flight.
module axi_sram_bridge_mp
  import axi_sram_bridge_mp_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned RD_OUTSTANDING = 2
) (
  input  logic                   aclk,
  input  logic                   areset,
  output logic [3:0]             arid,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [3:0]             rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [3:0]             awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [3:0]             wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [3:0]             bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [NUM_PORTS-1:0]   sram_req,
  input  logic [NUM_PORTS-1:0]   sram_wr,
  input  logic [2*NUM_PORTS-1:0] sram_size,
  input  logic [4*NUM_PORTS-1:0] sram_wstrb,
  input  logic [32*NUM_PORTS-1:0] sram_addr,
  input  logic [32*NUM_PORTS-1:0] sram_wdata,
  output logic [NUM_PORTS-1:0]   sram_addr_ok,
  output logic [NUM_PORTS-1:0]   sram_data_ok,
  output logic [31:0]            sram_rdata
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = $clog2(RD_OUTSTANDING + 1);

  rd_state_t     r_rd_state;
  wr_state_t     r_wr_state;
  logic [PW-1:0] r_rd_port, r_wr_port;
  logic [31:0]   r_araddr, r_awaddr, r_wdata;
  logic [2:0]    r_arsize, r_awsize;
  logic [3:0]    r_wstrb;
  logic          r_arvalid, r_awvalid, r_wvalid, r_bready;
  logic [CW-1:0] r_rd_cnt [NUM_PORTS];

  logic [NUM_PORTS-1:0] w_elig, w_grant, w_rd_grant, w_wr_grant, w_raw, w_inc, w_dec;
  logic [PW-1:0]        w_sel_port;
  logic [31:0]          w_sel_addr, w_sel_wdata;
  logic [3:0]           w_sel_wstrb;
  logic [1:0]           w_sel_size;
  logic                 w_ar_hs, w_aw_hs, w_w_hs, w_b_acc, w_r_acc, w_rready;
  logic                 w_unused_inputs;

  assign w_unused_inputs = ^{rresp, bresp, rlast};

`ifdef AXI_RAW_HAZARD_CHECK_EN
  always_comb begin
    w_raw = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      w_raw[p] = (r_wr_state != W_IDLE) && (sram_addr[p*32+2 +: 30] == r_awaddr[31:2]);
  end
`else
  assign w_raw = '0;
`endif

  always_comb begin
    w_elig = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (sram_wr[p]) w_elig[p] = sram_req[p] && (r_wr_state == W_IDLE);
      else            w_elig[p] = sram_req[p] && (r_rd_state == R_IDLE) &&
                                  (r_rd_cnt[p] < CW'(RD_OUTSTANDING)) && !w_raw[p];
    end
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .i_clk    (aclk),
    .i_rst    (areset),
    .i_req    (w_elig),
    .i_accept (|w_grant),
    .o_grant  (w_grant)
  );

  assign w_rd_grant = w_grant & ~sram_wr;
  assign w_wr_grant = w_grant & sram_wr;

  always_comb begin
    w_sel_port  = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    w_sel_size  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel_port  = PW'(p);
        w_sel_addr  = sram_addr[p*32 +: 32];
        w_sel_wdata = sram_wdata[p*32 +: 32];
        w_sel_wstrb = sram_wstrb[p*4 +: 4];
        w_sel_size  = sram_size[p*2 +: 2];
      end
    end
  end

  assign w_ar_hs  = r_arvalid & arready;
  assign w_aw_hs  = r_awvalid & awready;
  assign w_w_hs   = r_wvalid & wready;
  assign w_b_acc  = r_bready & bvalid;
  // B wins when both returns target the same port in one cycle
  assign w_rready = !(w_b_acc && rvalid && (rid == bid));
  assign w_r_acc  = rvalid & w_rready;

  always_comb begin
    sram_addr_ok = '0;
    sram_data_ok = '0;
    w_inc        = '0;
    w_dec        = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_inc[p] = w_ar_hs && (r_rd_port == PW'(p));
      w_dec[p] = w_r_acc && (rid == 4'(p));
      if (!areset) begin
        sram_addr_ok[p] = w_wr_grant[p] | w_inc[p];
        sram_data_ok[p] = w_dec[p] | (w_b_acc && (bid == 4'(p)));
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (areset)                     r_rd_cnt[p] <= '0;
      else if (w_inc[p] && !w_dec[p]) r_rd_cnt[p] <= r_rd_cnt[p] + 1'b1;
      else if (!w_inc[p] && w_dec[p]) r_rd_cnt[p] <= r_rd_cnt[p] - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rd_state <= R_IDLE;
      r_arvalid  <= 1'b0;
      r_rd_port  <= '0;
      r_araddr   <= '0;
      r_arsize   <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (|w_rd_grant) begin
          r_rd_state <= R_ADDR;
          r_arvalid  <= 1'b1;
          r_rd_port  <= w_sel_port;
          r_araddr   <= w_sel_addr;
          r_arsize   <= {1'b0, w_sel_size};
        end
        R_ADDR: if (arready) begin
          r_rd_state <= R_IDLE;
          r_arvalid  <= 1'b0;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_state <= W_IDLE;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_wr_port  <= '0;
      r_awaddr   <= '0;
      r_awsize   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: if (|w_wr_grant) begin
          r_wr_state <= W_AW_W;
          r_awvalid  <= 1'b1;
          r_wvalid   <= 1'b1;
          r_wr_port  <= w_sel_port;
          r_awaddr   <= w_sel_addr;
          r_awsize   <= {1'b0, w_sel_size};
          r_wdata    <= w_sel_wdata;
          r_wstrb    <= w_sel_wstrb;
        end
        W_AW_W: begin
          case ({w_aw_hs, w_w_hs})
            2'b11: begin
              r_wr_state <= W_RESP;
              r_awvalid  <= 1'b0;
              r_wvalid   <= 1'b0;
              r_bready   <= 1'b1;
            end
            2'b10: begin
              r_wr_state <= W_W;
              r_awvalid  <= 1'b0;
            end
            2'b01: begin
              r_wr_state <= W_AW;
              r_wvalid   <= 1'b0;
            end
            default: ;
          endcase
        end
        W_AW: if (awready) begin
          r_wr_state <= W_RESP;
          r_awvalid  <= 1'b0;
          r_bready   <= 1'b1;
        end
        W_W: if (wready) begin
          r_wr_state <= W_RESP;
          r_wvalid   <= 1'b0;
          r_bready   <= 1'b1;
        end
        W_RESP: if (bvalid) begin
          r_wr_state <= W_IDLE;
          r_bready   <= 1'b0;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  assign arid       = 4'(r_rd_port);
  assign araddr     = r_araddr;
  assign arlen      = AXI_LEN_SINGLE;
  assign arsize     = r_arsize;
  assign arburst    = AXI_BURST_INCR;
  assign arlock     = '0;
  assign arcache    = '0;
  assign arprot     = '0;
  assign arvalid    = r_arvalid;
  assign rready     = w_rready;
  assign awid       = 4'(r_wr_port);
  assign awaddr     = r_awaddr;
  assign awlen      = AXI_LEN_SINGLE;
  assign awsize     = r_awsize;
  assign awburst    = AXI_BURST_INCR;
  assign awlock     = '0;
  assign awcache    = '0;
  assign awprot     = '0;
  assign awvalid    = r_awvalid;
  assign wid        = 4'(r_wr_port);
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign wlast      = 1'b1;
  assign wvalid     = r_wvalid;
  assign bready     = r_bready;
  assign sram_rdata = rdata;

endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Bench for axi_sram_bridge_mp: directed scenarios plus random single
// transactions against a byte-lane memory model. Honours
// AXI_RAW_HAZARD_CHECK_EN the same way the design does.
`timescale 1ns/1ps
module tb_axi_sram_bridge_mp;

  localparam int unsigned NP = 2;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [3:0] arid;  logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0] arburst, arlock; logic [3:0] arcache; logic [2:0] arprot;
  logic arvalid, arready = 1'b0;
  logic [3:0] rid = '0; logic [31:0] rdata = '0; logic [1:0] rresp = '0;
  logic rlast = 1'b1, rvalid = 1'b0, rready;
  logic [3:0] awid;  logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0] awburst, awlock; logic [3:0] awcache; logic [2:0] awprot;
  logic awvalid, awready = 1'b0;
  logic [3:0] wid; logic [31:0] wdata; logic [3:0] wstrb; logic wlast, wvalid;
  logic wready = 1'b0;
  logic [3:0] bid = '0; logic [1:0] bresp = '0; logic bvalid = 1'b0, bready;
  logic [NP-1:0] sram_req = '0, sram_wr = '0;
  logic [2*NP-1:0] sram_size = '0;
  logic [4*NP-1:0] sram_wstrb = '0;
  logic [32*NP-1:0] sram_addr = '0, sram_wdata = '0;
  logic [NP-1:0] sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;

  axi_sram_bridge_mp #(.NUM_PORTS(NP), .RD_OUTSTANDING(2)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [16];   // what the ports asked for
  logic [31:0] slv_mem [16];   // what the slave saw on AW/W

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk); #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    sram_req[p] = 1'b1;
    sram_wr[p]  = wr;
    sram_addr[p*32 +: 32]  = a;
    sram_wdata[p*32 +: 32] = d;
    sram_wstrb[p*4 +: 4]   = s;
    sram_size[p*2 +: 2]    = 2'd2;
  endtask

  task automatic clr_req(input int p);
    sram_req[p] = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic do_reset;
    areset = 1'b1;
    arready = 0; awready = 0; wready = 0;
    sram_req = '0;
    set_req(0, 1'b1, 32'h0, 32'h0, 4'hF);
    rvalid = 1'b1; rid = 4'd0; bvalid = 1'b1; bid = 4'd0;
    tick; tick;
    chk("rst_valids", {arvalid, awvalid, wvalid, bready}, 4'b0000);
    chk("rst_addr_ok", sram_addr_ok, '0);
    chk("rst_data_ok", sram_data_ok, '0);
    rvalid = 1'b0; bvalid = 1'b0; sram_req = '0;
    areset = 1'b0;
    settle;
  endtask

  task automatic do_read(input int p, input logic [31:0] a);
    logic [31:0] ca;
    logic [3:0]  cid;
    set_req(p, 1'b0, a, 32'h0, 4'h0);
    for (int i = 0; i < 30 && !arvalid; i++) tick;
    chk("rd_arvalid", arvalid, 1);
    repeat ($urandom_range(0, 3)) begin
      chk("rd_no_early_ok", sram_addr_ok, '0);
      tick;
    end
    arready = 1'b1; settle;
    chk("rd_addr_ok", sram_addr_ok, 1 << p);
    chk("rd_araddr", araddr, a);
    chk("rd_arid", arid, p);
    chk("rd_arsize", arsize, 3'd2);
    ca = araddr; cid = arid;
    tick; arready = 1'b0; clr_req(p);
    repeat ($urandom_range(0, 3)) tick;
    rvalid = 1'b1; rid = cid; rdata = slv_mem[ca[5:2]]; settle;
    chk("rd_data_ok", sram_data_ok, 1 << p);
    chk("rd_rdata", sram_rdata, ref_mem[a[5:2]]);
    tick; rvalid = 1'b0; settle;
  endtask

  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic aw_done, w_done;
    logic [31:0] ca, cd;
    logic [3:0]  cs, cid;
    set_req(p, 1'b1, a, d, s); settle;
    chk("wr_addr_ok", sram_addr_ok, 1 << p);
    tick; clr_req(p);
    aw_done = 0; w_done = 0; ca = '0; cd = '0; cs = '0; cid = '0;
    for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      settle;
      if (awvalid && awready) begin aw_done = 1; ca = awaddr; cid = awid; end
      if (wvalid && wready)   begin w_done = 1; cd = wdata; cs = wstrb; end
      tick;
    end
    awready = 0; wready = 0; settle;
    chk("wr_both_done", {aw_done, w_done}, 2'b11);
    chk("wr_bready", bready, 1);
    chk("wr_awaddr", ca, a);
    chk("wr_awid", cid, p);
    chk("wr_wstrb", cs, s);
    slv_mem[ca[5:2]] = merge(slv_mem[ca[5:2]], cd, cs);
    ref_mem[a[5:2]]  = merge(ref_mem[a[5:2]], d, s);
    bvalid = 1'b1; bid = cid; settle;
    chk("wr_data_ok", sram_data_ok, 1 << p);
    tick; bvalid = 1'b0; settle;
    chk("wr_bready_low", bready, 0);
  endtask

  initial begin
    int n;
    int first_ar;
    int stall_ars;
    int ok_cnt;
    logic [3:0] exp_ids [4];
    exp_ids[0] = 4'd0; exp_ids[1] = 4'd1; exp_ids[2] = 4'd0; exp_ids[3] = 4'd1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h0101_0101 * i;
      slv_mem[i] = 32'h0101_0101 * i;
    end

    // single read, delayed arready
    do_reset;
    set_req(0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0); settle;
    chk("s1_grant_no_ok", sram_addr_ok, '0);
    tick;
    chk("s1_arvalid", arvalid, 1);
    chk("s1_araddr", araddr, 32'h1C00_0000);
    chk("s1_arid", arid, 0);
    chk("s1_arlen", arlen, 0);
    chk("s1_arburst", arburst, 2'b01);
    chk("s1_arsize", arsize, 3'b010);
    chk("s1_lcp", {arlock, arcache, arprot}, 0);
    chk("s1_wait_ok", sram_addr_ok, '0);
    tick; tick;
    arready = 1'b1; settle;
    chk("s1_addr_ok", sram_addr_ok, 2'b01);
    tick; arready = 1'b0; clr_req(0); settle;
    chk("s1_arvalid_low", arvalid, 0);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF; settle;
    chk("s1_rready", rready, 1);
    chk("s1_data_ok", sram_data_ok, 2'b01);
    chk("s1_rdata", sram_rdata, 32'hDEAD_BEEF);
    tick; rvalid = 1'b0; settle;
    chk("s1_data_ok_low", sram_data_ok, '0);

    // alternating grants, per-port read limit
    do_reset;
    arready = 1'b1;
    set_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h104, 32'h0, 4'h0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick;
      if (arvalid) begin
        chk($sformatf("s2_order_%0d", n), arid, exp_ids[n]);
        n++;
      end
    end
    chk("s2_ar_count", n, 4);
    stall_ars = 0;
    for (int i = 0; i < 8; i++) begin tick; if (arvalid) stall_ars++; end
    chk("s2_stalled", stall_ars, 0);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1234_5678; settle;
    chk("s2_ret1_ok", sram_data_ok, 2'b10);
    tick; rvalid = 1'b0;
    for (int i = 0; i < 10 && !arvalid; i++) tick;
    chk("s2_p1_reissue", arvalid, 1);
    chk("s2_p1_reissue_id", arid, 1);
    tick;

    // reset with reads outstanding
    do_reset;
    ok_cnt = 0;
    for (int i = 0; i < 5; i++) begin tick; if (sram_data_ok != '0) ok_cnt++; end
    chk("s6_no_data_ok", ok_cnt, 0);
    arready = 1'b1;
    set_req(0, 1'b0, 32'h108, 32'h0, 4'h0);
    n = 0;
    for (int i = 0; i < 12; i++) begin tick; if (arvalid && arid == 4'd0) n++; end
    chk("s6_cnt_cleared", n, 2);
    clr_req(0); arready = 1'b0;

    // port1 write, AW accepted before W
    do_reset;
    set_req(1, 1'b1, 32'h10, 32'hA5A5_1234, 4'b0011); settle;
    chk("s3_addr_ok", sram_addr_ok, 2'b10);
    tick; clr_req(1); settle;
    chk("s3_valids", {awvalid, wvalid}, 2'b11);
    chk("s3_awaddr", awaddr, 32'h10);
    chk("s3_ids", {awid, wid}, 8'h11);
    chk("s3_wstrb", wstrb, 4'b0011);
    chk("s3_wdata", wdata, 32'hA5A5_1234);
    chk("s3_awfix", {awlen, awburst, awsize, wlast}, {8'd0, 2'b01, 3'b010, 1'b1});
    awready = 1'b1; settle; tick; awready = 1'b0; settle;
    chk("s3_after_aw", {awvalid, wvalid, bready}, 3'b010);
    wready = 1'b1; settle; tick; wready = 1'b0; settle;
    chk("s3_after_w", {awvalid, wvalid, bready}, 3'b001);
    chk("s3_no_early_ok", sram_data_ok, '0);
    bvalid = 1'b1; bid = 4'd1; settle;
    chk("s3_data_ok", sram_data_ok, 2'b10);
    tick; bvalid = 1'b0; settle;
    chk("s3_bready_low", bready, 0);

    // R and B return to the same port together, then to different ports
    do_reset;
    arready = 1'b1;
    set_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
    for (int i = 0; i < 10 && !arvalid; i++) tick;
    tick; clr_req(1);
    set_req(0, 1'b0, 32'h44, 32'h0, 4'h0);
    for (int i = 0; i < 10 && !arvalid; i++) tick;
    tick; clr_req(0); arready = 1'b0;
    set_req(1, 1'b1, 32'h48, 32'h0, 4'hF); settle; tick; clr_req(1);
    awready = 1'b1; wready = 1'b1; settle; tick; awready = 1'b0; wready = 1'b0; settle;
    chk("s4_bready", bready, 1);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_2222; bvalid = 1'b1; bid = 4'd1; settle;
    chk("s4_rready_low", rready, 0);
    chk("s4_b_first", sram_data_ok, 2'b10);
    tick; bvalid = 1'b0; settle;
    chk("s4_rready_high", rready, 1);
    chk("s4_r_next", sram_data_ok, 2'b10);
    chk("s4_rdata", sram_rdata, 32'h1111_2222);
    tick; rvalid = 1'b0;
    set_req(1, 1'b1, 32'h4C, 32'h0, 4'hF); settle; tick; clr_req(1);
    awready = 1'b1; wready = 1'b1; settle; tick; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h3333_4444; bvalid = 1'b1; bid = 4'd1; settle;
    chk("s4_diff_rready", rready, 1);
    chk("s4_diff_both", sram_data_ok, 2'b11);
    chk("s4_diff_rdata", sram_rdata, 32'h3333_4444);
    tick; rvalid = 1'b0; bvalid = 1'b0; settle;

    // read of the word under an in-flight write
    do_reset;
    arready = 1'b1;
    set_req(0, 1'b1, 32'h20, 32'h0, 4'hF); settle; tick; clr_req(0);
    set_req(1, 1'b0, 32'h23, 32'h0, 4'h0);
    first_ar = -1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (arvalid && first_ar < 0) first_ar = i;
    end
`ifdef AXI_RAW_HAZARD_CHECK_EN
    chk("s5_raw_blocked", first_ar, -1);
`else
    chk("s5_raw_free", first_ar, 1);
`endif
    awready = 1'b1; wready = 1'b1; settle; tick; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bid = 4'd0; settle;
    chk("s5_b_ok", sram_data_ok, 2'b01);
    tick; bvalid = 1'b0; settle;
`ifdef AXI_RAW_HAZARD_CHECK_EN
    chk("s5_hold_at_b", arvalid, 0);
    tick;
    chk("s5_after_b", arvalid, 1);
    chk("s5_after_b_addr", araddr, 32'h23);
`endif
    clr_req(1); arready = 1'b0;

    // random single transactions against the memory model
    do_reset;
    for (int k = 0; k < 40; k++) begin
      int p;
      logic [31:0] a;
      p = int'($urandom_range(0, NP - 1));
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write(p, a, $urandom, 4'($urandom_range(1, 15)));
      else
        do_read(p, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
